axi_led_pwm_ctrl: RTL and testbench

//  LED output stage fed by the AXI4-Lite slave register file (slv_reg0..3) of my_axi_ip.

---
 rtl/axi_led_pwm_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_axi_led_pwm_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_led_pwm_ctrl.sv
// LED output stage driven from the AXI4-Lite register file.
// Turns the control/duty/period/pattern registers into static, PWM-dimmed,
// blinking or rotating LED drive. Register writes go through a shadow stage
// so that changes take effect only on PWM period boundaries.
module axi_led_pwm_ctrl #(
  parameter int NUM_LEDS           = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TICK_DIV           = 100
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_ctrl,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_duty,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_period,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_pattern,
  input  logic [3:0]                    cfg_wr,
  output logic [NUM_LEDS-1:0]           led_out,
  output logic [31:0]                   status
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_PWM    = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_SYNC = 2'd2
  } state_e;

  state_e               state_q;
  logic [DIV_W-1:0]     div_cnt_q;
  logic [7:0]           pwm_cnt_q;
  logic [15:0]          ph_cnt_q;
  logic                 phase_q;
  logic [NUM_LEDS-1:0]  rot_pat_q;
  logic                 pend_flag_q;
  logic [1:0]           pend_mode_q, act_mode_q;
  logic [7:0]           pend_duty_q, act_duty_q;
  logic [15:0]          pend_period_q, act_period_q;
  logic [NUM_LEDS-1:0]  pend_pattern_q, act_pattern_q;
  logic [NUM_LEDS-1:0]  led_q;
  logic [31:0]          status_q;

  logic                 tick_s, boundary_s, ph_term_s, pwm_on_s, shadow_wr_s, en_wr_s, dis_wr_s;
  logic [15:0]          per_last_s;
  logic [1:0]           pend_mode_d;
  logic [7:0]           pend_duty_d;
  logic [15:0]          pend_period_d;
  logic [NUM_LEDS-1:0]  pend_pattern_d, rot_next_s, led_d;
  logic                 unused_s;

  // Upper register bits carry no meaning for this block.
  assign unused_s = ^{cfg_ctrl[C_S_AXI_DATA_WIDTH-1:3], cfg_duty[C_S_AXI_DATA_WIDTH-1:8],
                      cfg_period[C_S_AXI_DATA_WIDTH-1:16], cfg_pattern[C_S_AXI_DATA_WIDTH-1:NUM_LEDS]};

  // Tick, boundary, phase terminal count and next pending register values.
  always_comb begin
    tick_s      = (state_q != ST_OFF) && (div_cnt_q == DIV_W'(TICK_DIV - 1));
    boundary_s  = tick_s && (pwm_cnt_q == 8'hFF);
    per_last_s  = (act_period_q == 16'd0) ? 16'd0 : (act_period_q - 16'd1);
    ph_term_s   = tick_s && (ph_cnt_q == per_last_s);
    pwm_on_s    = (act_duty_q == 8'hFF) || (pwm_cnt_q < act_duty_q);
    en_wr_s     = cfg_wr[0] && cfg_ctrl[0];
    dis_wr_s    = cfg_wr[0] && !cfg_ctrl[0];
    shadow_wr_s = (|cfg_wr[3:1]) || en_wr_s;
    pend_mode_d    = cfg_wr[0] ? cfg_ctrl[2:1]           : pend_mode_q;
    pend_duty_d    = cfg_wr[1] ? cfg_duty[7:0]           : pend_duty_q;
    pend_period_d  = cfg_wr[2] ? cfg_period[15:0]        : pend_period_q;
    pend_pattern_d = cfg_wr[3] ? cfg_pattern[NUM_LEDS-1:0] : pend_pattern_q;
    for (int i = 0; i < NUM_LEDS; i++) begin
      rot_next_s[i] = rot_pat_q[(i + NUM_LEDS - 1) % NUM_LEDS];
    end
  end

  // LED drive derived from the active mode and current counter state.
  always_comb begin
    led_d = '0;
    if (state_q == ST_OFF) begin
      led_d = '0;
    end else begin
      case (act_mode_q)
        MODE_STATIC: led_d = act_pattern_q;
        MODE_PWM:    led_d = act_pattern_q & {NUM_LEDS{pwm_on_s}};
        MODE_BLINK:  led_d = act_pattern_q & {NUM_LEDS{phase_q}};
        MODE_ROTATE: led_d = rot_pat_q;
        default:     led_d = '0;
      endcase
    end
  end

  // Control FSM, counters, shadow/active register copies and registered outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q        <= ST_OFF;
      div_cnt_q      <= '0;
      pwm_cnt_q      <= 8'd0;
      ph_cnt_q       <= 16'd0;
      phase_q        <= 1'b0;
      rot_pat_q      <= '0;
      pend_flag_q    <= 1'b0;
      pend_mode_q    <= 2'b00;
      pend_duty_q    <= 8'd0;
      pend_period_q  <= 16'd0;
      pend_pattern_q <= '0;
      act_mode_q     <= 2'b00;
      act_duty_q     <= 8'd0;
      act_period_q   <= 16'd0;
      act_pattern_q  <= '0;
      led_q          <= '0;
      status_q       <= 32'd0;
    end else begin
      led_q    <= led_d;
      status_q <= {16'h0000, pwm_cnt_q, 5'b00000, phase_q, pend_flag_q, (state_q != ST_OFF)};
      pend_mode_q    <= pend_mode_d;
      pend_duty_q    <= pend_duty_d;
      pend_period_q  <= pend_period_d;
      pend_pattern_q <= pend_pattern_d;
      case (state_q)
        ST_OFF: begin
          // While stopped there is no period to wait for: writes apply directly.
          div_cnt_q     <= '0;
          pwm_cnt_q     <= 8'd0;
          ph_cnt_q      <= 16'd0;
          phase_q       <= 1'b0;
          pend_flag_q   <= 1'b0;
          act_mode_q    <= pend_mode_d;
          act_duty_q    <= pend_duty_d;
          act_period_q  <= pend_period_d;
          act_pattern_q <= pend_pattern_d;
          if (en_wr_s) begin
            state_q   <= ST_RUN;
            rot_pat_q <= pend_pattern_d;
            phase_q   <= 1'b1;
          end else begin
            state_q   <= ST_OFF;
          end
        end
        ST_RUN, ST_SYNC: begin
          if (dis_wr_s) begin
            state_q     <= ST_OFF;
            div_cnt_q   <= '0;
            pwm_cnt_q   <= 8'd0;
            ph_cnt_q    <= 16'd0;
            phase_q     <= 1'b0;
            pend_flag_q <= 1'b0;
          end else begin
            div_cnt_q <= tick_s ? '0 : (div_cnt_q + DIV_W'(1));
            pwm_cnt_q <= tick_s ? (pwm_cnt_q + 8'd1) : pwm_cnt_q;
            if (ph_term_s) begin
              ph_cnt_q <= 16'd0;
              phase_q  <= ~phase_q;
              if (act_mode_q == MODE_ROTATE) begin
                rot_pat_q <= rot_next_s;
              end else begin
                rot_pat_q <= rot_pat_q;
              end
            end else if (tick_s) begin
              ph_cnt_q <= ph_cnt_q + 16'd1;
            end else begin
              ph_cnt_q <= ph_cnt_q;
            end
            // Boundary load uses the pending copy as it stood before this edge,
            // so a coincident write waits for the following boundary.
            if (boundary_s && pend_flag_q) begin
              act_mode_q    <= pend_mode_q;
              act_duty_q    <= pend_duty_q;
              act_period_q  <= pend_period_q;
              act_pattern_q <= pend_pattern_q;
              rot_pat_q     <= pend_pattern_q;
              ph_cnt_q      <= 16'd0;
              pend_flag_q   <= shadow_wr_s;
              state_q       <= shadow_wr_s ? ST_SYNC : ST_RUN;
            end else if (shadow_wr_s) begin
              pend_flag_q <= 1'b1;
              state_q     <= ST_SYNC;
            end else begin
              state_q     <= state_q;
            end
          end
        end
        default: begin
          state_q <= ST_OFF;
        end
      endcase
    end
  end

  assign led_out = led_q;
  assign status  = status_q;

endmodule

// File: tb/tb_axi_led_pwm_ctrl.sv
// Self-checking bench for axi_led_pwm_ctrl: directed scenarios plus randomized
// sessions, compared against an arithmetic reference model of the LED drive.
module tb_axi_led_pwm_ctrl;

  localparam int TD  = 4;
  localparam int BIG = 1 << 30;

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] cfg_ctrl, cfg_duty, cfg_period, cfg_pattern;
  logic [3:0]  cfg_wr;
  logic [3:0]  led_out;
  logic [31:0] status;

  int tests = 0;
  int fails = 0;
  int kk;
  int m_mode, m_period, m_duty1, m_duty2, m_duty3;
  int sw1, sw2, pf1, pt1, pf2, pt2;
  logic [3:0] m_pat;

  axi_led_pwm_ctrl #(
    .NUM_LEDS(4),
    .C_S_AXI_DATA_WIDTH(32),
    .TICK_DIV(TD)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .cfg_ctrl(cfg_ctrl),
    .cfg_duty(cfg_duty),
    .cfg_period(cfg_period),
    .cfg_pattern(cfg_pattern),
    .cfg_wr(cfg_wr),
    .led_out(led_out),
    .status(status)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Duty in force for internal state index m (edges since enable capture).
  function automatic int duty_at(int m);
    if (m >= sw2) return m_duty3;
    if (m >= sw1) return m_duty2;
    return m_duty1;
  endfunction

  // Expected LED drive one edge after internal state index m.
  function automatic logic [3:0] exp_led(int m);
    int t, pc, p, s, d;
    logic [7:0] dbl;
    t  = m / TD;
    pc = t % 256;
    p  = (m_period == 0) ? 1 : m_period;
    s  = t / p;
    d  = duty_at(m);
    case (m_mode)
      0: return m_pat;
      1: return ((d == 255) || (pc < d)) ? m_pat : 4'h0;
      2: return ((s % 2) == 0) ? m_pat : 4'h0;
      default: begin
        dbl = {m_pat, m_pat} << (s % 4);
        return dbl[7:4];
      end
    endcase
  endfunction

  // Expected status word one edge after internal state index m.
  function automatic logic [31:0] exp_status(int m);
    int t, p;
    logic ph, pd;
    t  = m / TD;
    p  = (m_period == 0) ? 1 : m_period;
    ph = ((t / p) % 2) == 0;
    pd = ((m >= pf1) && (m < pt1)) || ((m >= pf2) && (m < pt2));
    return {16'h0000, 8'(t % 256), 5'b00000, ph, pd, 1'b1};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s k=%0d: observed %0h expected %0h", tag, kk, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // One clock of a running session, checked against the model.
  task automatic run1();
    step();
    kk++;
    check("led", {28'h0, led_out}, {28'h0, exp_led(kk - 1)});
    check("status", status, exp_status(kk - 1));
  endtask

  // Stop, program the registers (with random junk in ignored bits), then enable.
  task automatic start(int mode, logic [3:0] pat, int duty, int period);
    cfg_ctrl = $urandom() & 32'hFFFF_FFFE;
    cfg_wr = 4'b0001;
    step();
    cfg_wr = 4'b0000;
    step();
    step();
    cfg_duty    = ($urandom() & 32'hFFFF_FF00) | 32'(duty);
    cfg_period  = ($urandom() & 32'hFFFF_0000) | 32'(period);
    cfg_pattern = ($urandom() & 32'hFFFF_FFF0) | {28'h0, pat};
    cfg_wr = 4'b1110;
    step();
    cfg_wr = 4'b0000;
    cfg_ctrl = ($urandom() & 32'hFFFF_FFF8) | {29'h0, 2'(mode), 1'b1};
    cfg_wr = 4'b0001;
    step();
    cfg_wr = 4'b0000;
    m_mode = mode; m_pat = pat; m_period = period;
    m_duty1 = duty; m_duty2 = duty; m_duty3 = duty;
    sw1 = BIG; sw2 = BIG; pf1 = BIG; pt1 = BIG; pf2 = BIG; pt2 = BIG;
    kk = 0;
    check("en_lat0", {28'h0, led_out}, 32'h0);
  endtask

  initial begin
    int cnt;
    kk = 0;
    ARESETN = 1'b0;
    cfg_ctrl = 32'h0; cfg_duty = 32'h0; cfg_period = 32'h0; cfg_pattern = 32'h0;
    cfg_wr = 4'b0000;
    step();
    check("reset_led", {28'h0, led_out}, 32'h0);
    check("reset_status", status, 32'h0);
    step();
    ARESETN = 1'b1;
    step();

    // Static pattern, then disable.
    start(0, 4'b1010, 0, 0);
    repeat (3) run1();
    cfg_ctrl = 32'h0; cfg_wr = 4'b0001;
    step();
    cfg_wr = 4'b0000;
    step();
    check("static_off", {28'h0, led_out}, 32'h0);
    check("static_off_status", status, 32'h0);

    // PWM duty cycle counts over one full period.
    start(1, 4'hF, 64, 0);
    cnt = 0;
    repeat (1024) begin run1(); if (led_out == 4'hF) cnt++; end
    check("pwm64_cnt", cnt, 256);
    start(1, 4'hF, 0, 0);
    cnt = 0;
    repeat (1024) begin run1(); if (led_out == 4'hF) cnt++; end
    check("pwm0_cnt", cnt, 0);
    start(1, 4'hF, 255, 0);
    cnt = 0;
    repeat (1024) begin run1(); if (led_out == 4'hF) cnt++; end
    check("pwm255_cnt", cnt, 1024);

    // Blink with period 3 and period 0, rotate with period 1.
    start(2, 4'b0110, 0, 3);
    repeat (60) run1();
    start(2, 4'b0110, 0, 0);
    repeat (24) run1();
    start(3, 4'b0001, 0, 1);
    repeat (24) run1();

    // Shadow: mid-period write, then a write exactly on a boundary.
    start(1, 4'hF, 64, 0);
    while (kk < 500) run1();
    m_duty2 = 200; sw1 = 1024; pf1 = kk + 1; pt1 = 1024;
    cfg_duty = 32'd200; cfg_wr = 4'b0010;
    run1();
    cfg_wr = 4'b0000;
    while (kk < 2047) run1();
    m_duty3 = 10; sw2 = 3072; pf2 = 2048; pt2 = 3072;
    cfg_duty = 32'hABCD_000A; cfg_wr = 4'b0010;
    run1();
    cfg_wr = 4'b0000;
    while (kk < 3300) run1();

    // Randomized sessions.
    for (int i = 0; i < 8; i++) begin
      int rm, rd, rp;
      logic [3:0] rpat;
      rm   = $urandom_range(0, 3);
      rpat = 4'($urandom_range(1, 15));
      rd   = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 40);
      rp   = $urandom_range(0, 4);
      start(rm, rpat, rd, rp);
      repeat (120) run1();
    end

    // Asynchronous reset mid-blink; must stay dark until re-enabled.
    start(2, 4'b0110, 0, 3);
    repeat (30) run1();
    #2 ARESETN = 1'b0;
    #1;
    check("rst_async_led", {28'h0, led_out}, 32'h0);
    check("rst_async_status", status, 32'h0);
    step();
    step();
    ARESETN = 1'b1;
    repeat (8) begin
      step();
      check("rst_hold_led", {28'h0, led_out}, 32'h0);
      check("rst_hold_status", status, 32'h0);
    end
    cfg_pattern = 32'h6; cfg_wr = 4'b1000;
    step();
    cfg_wr = 4'b0000;
    repeat (4) begin
      step();
      check("rst_noen_led", {28'h0, led_out}, 32'h0);
    end
    start(2, 4'b0110, 0, 3);
    repeat (30) run1();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
